// File: rtl/cache_axi_arbiter_if.sv
// Bundle of every bus signal around the cache-side memory arbiter.
//   m_*  : read request/return channel shared by icache (0) and dcache (1)
//   d_*  : dcache write-back channel into the one-entry write buffer
//   s_*  : downstream read/write port towards the AXI bridge
// Modports:
//   slave  - the arbiter's view (serves the caches, drives the downstream port)
//   master - the environment's view (caches plus downstream bridge)
interface cache_axi_arbiter_if;
    logic [1:0]   m_rd_req;
    logic [5:0]   m_rd_type;
    logic [63:0]  m_rd_addr;
    logic [1:0]   m_rd_rdy;
    logic [1:0]   m_ret_valid;
    logic         m_ret_last;
    logic [31:0]  m_ret_data;

    logic         d_wr_req;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         d_wr_rdy;

    logic         s_rd_req;
    logic [2:0]   s_rd_type;
    logic [31:0]  s_rd_addr;
    logic         s_rd_rdy;
    logic         s_ret_valid;
    logic         s_ret_last;
    logic [31:0]  s_ret_data;
    logic         s_wr_req;
    logic [2:0]   s_wr_type;
    logic [31:0]  s_wr_addr;
    logic [3:0]   s_wr_wstrb;
    logic [127:0] s_wr_data;
    logic         s_wr_rdy;

    modport slave (
        input  m_rd_req, m_rd_type, m_rd_addr,
        output m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
        input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        output d_wr_rdy,
        output s_rd_req, s_rd_type, s_rd_addr,
        input  s_rd_rdy, s_ret_valid, s_ret_last, s_ret_data,
        output s_wr_req, s_wr_type, s_wr_addr, s_wr_wstrb, s_wr_data,
        input  s_wr_rdy
    );

    modport master (
        output m_rd_req, m_rd_type, m_rd_addr,
        input  m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
        output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        input  d_wr_rdy,
        input  s_rd_req, s_rd_type, s_rd_addr,
        output s_rd_rdy, s_ret_valid, s_ret_last, s_ret_data,
        input  s_wr_req, s_wr_type, s_wr_addr, s_wr_wstrb, s_wr_data,
        output s_wr_rdy
    );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Shares one memory-side read/write port between the icache (requester 0)
// and the dcache (requester 1). Reads are arbitrated one at a time and the
// refill beats are routed back to the owner; dcache write-backs go through a
// one-entry write buffer. A read whose line sits in (or is entering) the write
// buffer is held off until the buffer drains.
// Ports:
//   clk    - clock, all logic on posedge
//   resetn - asynchronous active-low reset
//   bus    - cache_axi_arbiter_if.slave: m_* read channel, d_* write channel,
//            s_* downstream port
// Parameters:
//   RR_EN     - 1: round-robin between readers; 0: requester 1 always first
//   RAW_CHECK - 1: block reads that hit the write-buffer line
module cache_axi_arbiter #(
    parameter bit RR_EN     = 1'b1,
    parameter bit RAW_CHECK = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    cache_axi_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;

    rd_state_t    state, state_nxt;
    logic         last_grant;
    logic         owner;
    logic [2:0]   rd_type_q;
    logic [31:0]  rd_addr_q;

    logic         wb_valid;
    logic [2:0]   wb_type;
    logic [31:0]  wb_addr;
    logic [3:0]   wb_wstrb;
    logic [127:0] wb_data;

    logic         wr_accept;
    logic [27:0]  line0, line1;
    logic [1:0]   hazard, eligible;
    logic         grant_any, grant_idx;
    logic [1:0]   rd_rdy;
    logic [1:0]   ret_valid;
    logic         ret_last;

    assign wr_accept = bus.d_wr_req & ~wb_valid;
    assign line0     = bus.m_rd_addr[31:4];
    assign line1     = bus.m_rd_addr[63:36];

    // A write being accepted this very cycle counts as already buffered, so a
    // same-line read cannot slip past it.
    always_comb begin
        hazard = '0;
        if (RAW_CHECK) begin
            hazard[0] = (wb_valid  && line0 == wb_addr[31:4]) ||
                        (wr_accept && line0 == bus.d_wr_addr[31:4]);
            hazard[1] = (wb_valid  && line1 == wb_addr[31:4]) ||
                        (wr_accept && line1 == bus.d_wr_addr[31:4]);
        end
    end

    assign eligible  = bus.m_rd_req & ~hazard;
    assign grant_any = |eligible;

    // On a tie the requester that did not win last time goes first (RR), or
    // the dcache always goes first (fixed priority).
    always_comb begin
        grant_idx = 1'b0;
        case (eligible)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = RR_EN ? ~last_grant : 1'b1;
            default: grant_idx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= R_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            R_IDLE:  if (grant_any) state_nxt = R_REQ;
            R_REQ:   if (bus.s_rd_rdy) state_nxt = R_DATA;
            R_DATA:  if (bus.s_ret_valid && bus.s_ret_last) state_nxt = R_IDLE;
            default: state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        rd_rdy       = '0;
        ret_valid    = '0;
        ret_last     = 1'b0;
        bus.s_rd_req = 1'b0;
        case (state)
            R_IDLE:  if (grant_any) rd_rdy[grant_idx] = 1'b1;
            R_REQ:   bus.s_rd_req = 1'b1;
            R_DATA: begin
                ret_valid[owner] = bus.s_ret_valid;
                ret_last         = bus.s_ret_last;
            end
            default: ;
        endcase
    end

    assign bus.m_rd_rdy    = rd_rdy;
    assign bus.m_ret_valid = ret_valid;
    assign bus.m_ret_last  = ret_last;
    assign bus.m_ret_data  = bus.s_ret_data;
    assign bus.s_rd_type   = rd_type_q;
    assign bus.s_rd_addr   = rd_addr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            rd_type_q  <= '0;
            rd_addr_q  <= '0;
        end else if (state == R_IDLE && grant_any) begin
            last_grant <= grant_idx;
            owner      <= grant_idx;
            rd_type_q  <= grant_idx ? bus.m_rd_type[5:3]   : bus.m_rd_type[2:0];
            rd_addr_q  <= grant_idx ? bus.m_rd_addr[63:32] : bus.m_rd_addr[31:0];
        end
    end

    // Accept only while empty, so drain and refill never share a cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
            wb_type  <= '0;
            wb_addr  <= '0;
            wb_wstrb <= '0;
            wb_data  <= '0;
        end else if (wr_accept) begin
            wb_valid <= 1'b1;
            wb_type  <= bus.d_wr_type;
            wb_addr  <= bus.d_wr_addr;
            wb_wstrb <= bus.d_wr_wstrb;
            wb_data  <= bus.d_wr_data;
        end else if (wb_valid && bus.s_wr_rdy) begin
            wb_valid <= 1'b0;
        end
    end

    assign bus.d_wr_rdy   = ~wb_valid;
    assign bus.s_wr_req   = wb_valid;
    assign bus.s_wr_type  = wb_type;
    assign bus.s_wr_addr  = wb_addr;
    assign bus.s_wr_wstrb = wb_wstrb;
    assign bus.s_wr_data  = wb_data;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Bench for cache_axi_arbiter: directed scenarios followed by randomized
// read/write traffic compared against a line-level arbitration model.
module tb_cache_axi_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cache_axi_arbiter_if bus();
    cache_axi_arbiter_if bus_fp();

    cache_axi_arbiter #(.RR_EN(1'b1), .RAW_CHECK(1'b1)) dut (
        .clk(clk), .resetn(resetn), .bus(bus));
    cache_axi_arbiter #(.RR_EN(1'b0), .RAW_CHECK(1'b1)) dut_fp (
        .clk(clk), .resetn(resetn), .bus(bus_fp));

    // Fixed-priority instance sees exactly the same stimulus.
    assign bus_fp.m_rd_req    = bus.m_rd_req;
    assign bus_fp.m_rd_type   = bus.m_rd_type;
    assign bus_fp.m_rd_addr   = bus.m_rd_addr;
    assign bus_fp.d_wr_req    = bus.d_wr_req;
    assign bus_fp.d_wr_type   = bus.d_wr_type;
    assign bus_fp.d_wr_addr   = bus.d_wr_addr;
    assign bus_fp.d_wr_wstrb  = bus.d_wr_wstrb;
    assign bus_fp.d_wr_data   = bus.d_wr_data;
    assign bus_fp.s_rd_rdy    = bus.s_rd_rdy;
    assign bus_fp.s_ret_valid = bus.s_ret_valid;
    assign bus_fp.s_ret_last  = bus.s_ret_last;
    assign bus_fp.s_ret_data  = bus.s_ret_data;
    assign bus_fp.s_wr_rdy    = bus.s_wr_rdy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic clr();
        bus.m_rd_req = '0;  bus.m_rd_type = '0;  bus.m_rd_addr = '0;
        bus.d_wr_req = 1'b0; bus.d_wr_type = '0; bus.d_wr_addr = '0;
        bus.d_wr_wstrb = '0; bus.d_wr_data = '0;
        bus.s_rd_rdy = 1'b0; bus.s_ret_valid = 1'b0; bus.s_ret_last = 1'b0;
        bus.s_ret_data = '0; bus.s_wr_rdy = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        resetn = 1'b0;
        nxt();
        #1;
        chk("rst_d_wr_rdy", bus.d_wr_rdy, 1);
        chk("rst_s_rd_req", bus.s_rd_req, 0);
        chk("rst_s_wr_req", bus.s_wr_req, 0);
        chk("rst_ret_valid", bus.m_ret_valid, 0);
        chk("rst_rd_rdy", bus.m_rd_rdy, 0);
        chk("rst_s_rd_addr", bus.s_rd_addr, 0);
        chk("rst_s_wr_data", bus.s_wr_data, 0);
        nxt();
        resetn = 1'b1;
    endtask

    // Entered on the negedge of the first cycle after a grant. Plays the
    // downstream side of one read and checks routing back to 'own'.
    task automatic serve_read(input int own, input logic [31:0] addr,
                              input logic [2:0] typ, input int nb, input bit rnd);
        int waits;
        logic [31:0] d;
        #1;
        chk("req_rd_rdy_low", bus.m_rd_rdy, 0);
        bus.m_rd_req[own] = 1'b0;
        waits = rnd ? int'($urandom_range(0, 2)) : 0;
        for (int w = 0; w <= waits; w++) begin
            if (w > 0) begin nxt(); #1; end
            chk("s_rd_req", bus.s_rd_req, 1);
            chk("s_rd_addr", bus.s_rd_addr, addr);
            chk("s_rd_type", bus.s_rd_type, typ);
            if (w == waits) bus.s_rd_rdy = 1'b1;
        end
        nxt();
        bus.s_rd_rdy = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (rnd && ($urandom % 3) == 0) begin
                bus.s_ret_valid = 1'b0;
                bus.s_ret_last  = 1'($urandom);
                #1;
                chk("ret_gap_valid", bus.m_ret_valid, 0);
                nxt();
            end
            d = rnd ? $urandom : 32'h11 * (b + 1);
            bus.s_ret_valid = 1'b1;
            bus.s_ret_last  = (b == nb - 1);
            bus.s_ret_data  = d;
            #1;
            chk("ret_valid", bus.m_ret_valid, 2'b01 << own);
            chk("ret_last", bus.m_ret_last, (b == nb - 1));
            chk("ret_data", bus.m_ret_data, d);
            nxt();
        end
        bus.s_ret_valid = 1'b0;
        bus.s_ret_last  = 1'b0;
    endtask

    // Arbitration reference: a requester is eligible unless its line sits in
    // the write buffer; ties go to whoever did not win last (RR).
    function automatic logic [1:0] model_grant(input logic [1:0] req,
        input logic [31:0] a0, input logic [31:0] a1, input bit wbv,
        input logic [31:0] wba, input bit last);
        logic [1:0] ok;
        ok[0] = req[0] && !(wbv && a0[31:4] == wba[31:4]);
        ok[1] = req[1] && !(wbv && a1[31:4] == wba[31:4]);
        if (ok == 2'b11) return last ? 2'b01 : 2'b10;
        return ok;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   req, g;
        logic [31:0]  a0, a1, wa;
        logic [2:0]   t0, t1, wt;
        logic [3:0]   ws;
        logic [127:0] wd;
        bit           mwbv, mlast;
        int           own;

        do_reset();

        // T1: single icache line read
        bus.m_rd_req = 2'b01; bus.m_rd_addr = 64'h0000_0000_1c00_0010;
        bus.m_rd_type = 6'b000_100;
        #1 chk("t1_grant", bus.m_rd_rdy, 2'b01);
        nxt();
        serve_read(0, 32'h1c00_0010, 3'b100, 4, 1'b0);
        #1 chk("t1_idle_valid", bus.m_ret_valid, 0);
        chk("t1_idle_sreq", bus.s_rd_req, 0);

        // T2: both held; RR alternates, fixed priority always picks 1
        do_reset();
        bus.m_rd_req = 2'b11; bus.m_rd_addr = {32'h3000, 32'h2000};
        bus.m_rd_type = 6'b100_100;
        bus.s_rd_rdy = 1'b1; bus.s_ret_valid = 1'b1; bus.s_ret_last = 1'b1;
        bus.s_ret_data = 32'h55;
        for (int c = 0; c < 12; c++) begin
            #1;
            case (c % 3)
                0: begin
                    chk("t2_rr_grant", bus.m_rd_rdy, ((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
                    chk("t2_fp_grant", bus_fp.m_rd_rdy, 2'b10);
                end
                1: chk("t2_sreq", bus.s_rd_req, 1);
                default: begin
                    chk("t2_ret_owner", bus.m_ret_valid, ((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
                    chk("t2_fp_owner", bus_fp.m_ret_valid, 2'b10);
                end
            endcase
            nxt();
        end
        clr();

        // T3: write buffer holds steady while downstream stalls
        bus.d_wr_req = 1'b1; bus.d_wr_type = 3'b100; bus.d_wr_addr = 32'h1230;
        bus.d_wr_wstrb = 4'hf; bus.d_wr_data = 128'h0123456789abcdef0123456789abcdef;
        #1 chk("t3_accept_rdy", bus.d_wr_rdy, 1);
        chk("t3_no_sreq_yet", bus.s_wr_req, 0);
        nxt();
        bus.d_wr_req = 1'b0; bus.d_wr_addr = 32'hdeadbeef; bus.d_wr_data = '1;
        bus.d_wr_wstrb = 4'h0; bus.d_wr_type = 3'b000;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_sreq", bus.s_wr_req, 1);
            chk("t3_addr", bus.s_wr_addr, 32'h1230);
            chk("t3_data", bus.s_wr_data, 128'h0123456789abcdef0123456789abcdef);
            chk("t3_wstrb", bus.s_wr_wstrb, 4'hf);
            chk("t3_type", bus.s_wr_type, 3'b100);
            chk("t3_busy", bus.d_wr_rdy, 0);
            nxt();
        end
        bus.s_wr_rdy = 1'b1;
        #1 chk("t3_drain_cycle_busy", bus.d_wr_rdy, 0);
        nxt();
        bus.s_wr_rdy = 1'b0;
        #1 chk("t3_rdy_after_drain", bus.d_wr_rdy, 1);
        chk("t3_sreq_low", bus.s_wr_req, 0);

        // T4: read-after-write hazard on requester 1
        bus.d_wr_req = 1'b1; bus.d_wr_addr = 32'h1230; bus.d_wr_data = 128'h5;
        nxt();
        bus.d_wr_req = 1'b0;
        bus.m_rd_req = 2'b11; bus.m_rd_addr = {32'h0000_123c, 32'h0000_4000};
        bus.m_rd_type = 6'b000_100;
        #1 chk("t4_r0_first", bus.m_rd_rdy, 2'b01);
        nxt();
        serve_read(0, 32'h4000, 3'b100, 1, 1'b0);
        #1 chk("t4_r1_blocked", bus.m_rd_rdy, 0);
        nxt();
        #1 chk("t4_r1_blocked2", bus.m_rd_rdy, 0);
        bus.s_wr_rdy = 1'b1;
        chk("t4_blocked_drain_cycle", bus.m_rd_rdy, 0);
        nxt();
        bus.s_wr_rdy = 1'b0;
        #1 chk("t4_r1_granted", bus.m_rd_rdy, 2'b10);
        nxt();
        serve_read(1, 32'h123c, 3'b000, 2, 1'b0);

        // T5: write and same-line read in one cycle
        bus.d_wr_req = 1'b1; bus.d_wr_addr = 32'h5670;
        bus.m_rd_req = 2'b10; bus.m_rd_addr = {32'h5670, 32'h0};
        bus.m_rd_type = 6'b000_000;
        #1 chk("t5_wr_accepted", bus.d_wr_rdy, 1);
        chk("t5_rd_blocked", bus.m_rd_rdy, 0);
        nxt();
        bus.d_wr_req = 1'b0;
        #1 chk("t5_wb_full", bus.s_wr_req, 1);
        chk("t5_rd_still_blocked", bus.m_rd_rdy, 0);
        bus.s_wr_rdy = 1'b1;
        nxt();
        bus.s_wr_rdy = 1'b0;
        #1 chk("t5_rd_granted", bus.m_rd_rdy, 2'b10);
        nxt();
        serve_read(1, 32'h5670, 3'b000, 1, 1'b0);

        // T6: reset in the middle of a refill
        bus.m_rd_req = 2'b01; bus.m_rd_addr = {32'h0, 32'h1c00_0020};
        bus.m_rd_type = 6'b000_100;
        #1 chk("t6_grant", bus.m_rd_rdy, 2'b01);
        nxt();
        bus.m_rd_req = 2'b00;
        bus.s_rd_rdy = 1'b1;
        nxt();
        bus.s_rd_rdy = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.s_ret_valid = 1'b1; bus.s_ret_data = 32'h100 + b;
            #1 chk("t6_beat", bus.m_ret_valid, 2'b01);
            nxt();
        end
        resetn = 1'b0;
        #1 chk("t6_rst_valid", bus.m_ret_valid, 0);
        chk("t6_rst_sreq", bus.s_rd_req, 0);
        nxt();
        resetn = 1'b1;
        #1 chk("t6_idle_ignores_ret", bus.m_ret_valid, 0);
        nxt();
        bus.s_ret_valid = 1'b0;
        bus.m_rd_req = 2'b01; bus.m_rd_addr = {32'h0, 32'h1c00_0040};
        #1 chk("t6_fresh_grant", bus.m_rd_rdy, 2'b01);
        nxt();
        serve_read(0, 32'h1c00_0040, 3'b100, 4, 1'b0);

        // Randomized traffic against the model
        do_reset();
        mlast = 1'b1;
        mwbv  = 1'b0;
        wa = '0; wd = '0; ws = '0; wt = '0;
        for (int it = 0; it < 40; it++) begin
            if (($urandom % 2) == 0) begin
                wa = 32'h1000 + ($urandom % 64);
                wd = {$urandom, $urandom, $urandom, $urandom};
                ws = 4'($urandom);
                wt = 3'($urandom);
                bus.d_wr_req = 1'b1; bus.d_wr_addr = wa; bus.d_wr_data = wd;
                bus.d_wr_wstrb = ws; bus.d_wr_type = wt;
                #1 chk("rnd_wr_rdy", bus.d_wr_rdy, 1);
                nxt();
                bus.d_wr_req = 1'b0; bus.d_wr_addr = $urandom;
                mwbv = 1'b1;
            end
            req = 2'($urandom_range(1, 3));
            a0 = 32'h1000 + ($urandom % 64);
            a1 = 32'h1000 + ($urandom % 64);
            t0 = 3'($urandom);
            t1 = 3'($urandom);
            bus.m_rd_req = req; bus.m_rd_addr = {a1, a0}; bus.m_rd_type = {t1, t0};
            g = '0;
            for (int k = 0; k < 2 && g == 2'b00; k++) begin
                #1;
                g = model_grant(req, a0, a1, mwbv, wa, mlast);
                chk("rnd_grant", bus.m_rd_rdy, g);
                if (g == 2'b00) begin
                    chk("rnd_wb_pending", bus.s_wr_req, 1);
                    bus.s_wr_rdy = 1'b1;
                    nxt();
                    bus.s_wr_rdy = 1'b0;
                    mwbv = 1'b0;
                end
            end
            if (g != 2'b00) begin
                own = g[1] ? 1 : 0;
                mlast = g[1];
                nxt();
                serve_read(own, g[1] ? a1 : a0, g[1] ? t1 : t0,
                           int'($urandom_range(1, 4)), 1'b1);
            end
            bus.m_rd_req = 2'b00;
            if (mwbv) begin
                #1;
                chk("rnd_s_wr_req", bus.s_wr_req, 1);
                chk("rnd_s_wr_addr", bus.s_wr_addr, wa);
                chk("rnd_s_wr_data", bus.s_wr_data, wd);
                chk("rnd_s_wr_wstrb", bus.s_wr_wstrb, ws);
                chk("rnd_s_wr_type", bus.s_wr_type, wt);
                chk("rnd_wr_busy", bus.d_wr_rdy, 0);
                bus.s_wr_rdy = 1'b1;
                nxt();
                bus.s_wr_rdy = 1'b0;
                mwbv = 1'b0;
                #1 chk("rnd_wr_free", bus.d_wr_rdy, 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
